// File: rtl/capture_fifo_reader.sv
// Read side of the capture merge FIFO: pops 512-bit lines and unpacks them into
// eight 64-bit records (lane 7 first), optionally dropping all-ones tail padding.
module capture_fifo_reader #(
  parameter logic [63:0] PAD_WORD = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter bit          SKIP_PAD = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] fifo_dout_i,
  input  logic         fifo_empty_i,
  output logic         fifo_rd_en_o,
  output logic [63:0]  rec_data_o,
  output logic         rec_valid_o,
  input  logic         rec_ready_i,
  output logic         rec_last_o,
  output logic [31:0]  line_cnt_o,
  output logic [31:0]  pad_cnt_o,
  output logic         busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    UNPACK
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [7:0][63:0] line;
  logic [2:0]       lane;
  logic [2:0]       lane_next;
  logic [31:0]      line_cnt;
  logic [31:0]      pad_cnt;
  logic [63:0]      cur_word;
  logic [63:0]      nxt_word;
  logic             pad;
  logic             line_inc;
  logic             pad_inc;
  logic [3:0]       pad_lanes;

  assign cur_word  = line[lane];
  assign nxt_word  = line[lane - 3'd1];
  assign pad_lanes = {1'b0, lane} + 4'd1;

  always_comb begin
    state_next   = state;
    lane_next    = lane;
    fifo_rd_en_o = 1'b0;
    rec_data_o   = '0;
    rec_valid_o  = 1'b0;
    rec_last_o   = 1'b0;
    pad          = 1'b0;
    line_inc     = 1'b0;
    pad_inc      = 1'b0;
    unique case (state)
      IDLE: begin
        fifo_rd_en_o = !fifo_empty_i && !rst;
        if (fifo_rd_en_o) state_next = LOAD;
      end
      LOAD: begin
        lane_next  = 3'd7;
        line_inc   = 1'b1;
        state_next = UNPACK;
      end
      UNPACK: begin
        pad         = SKIP_PAD && (cur_word == PAD_WORD);
        rec_data_o  = cur_word;
        rec_valid_o = !pad;
        rec_last_o  = rec_valid_o && SKIP_PAD && (lane != 3'd0) && (nxt_word == PAD_WORD);
        if (pad) begin
          // Padding only sits at the tail, so everything from here down is dropped at once.
          pad_inc    = 1'b1;
          state_next = IDLE;
        end else if (rec_ready_i) begin
          if (lane == 3'd0) state_next = IDLE;
          else              lane_next  = lane - 3'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lane     <= 3'd7;
      line_cnt <= '0;
      pad_cnt  <= '0;
    end else begin
      state <= state_next;
      lane  <= lane_next;
      if (line_inc) line_cnt <= line_cnt + 32'd1;
      if (pad_inc)  pad_cnt  <= pad_cnt + {28'd0, pad_lanes};
    end
  end

  // NOTE: the line register carries no reset; it is only observed in UNPACK, which
  // is always preceded by a LOAD that overwrites it.
  always_ff @(posedge clk) begin
    if (state == LOAD) line <= fifo_dout_i;
  end

  assign line_cnt_o = line_cnt;
  assign pad_cnt_o  = pad_cnt;
  assign busy_o     = (state != IDLE);

endmodule

// File: tb/tb_capture_fifo_reader.sv
// Scoreboard bench for capture_fifo_reader: a FIFO model feeds lines, expected
// records are queued at push time and a negedge monitor compares handshakes.
module tb_capture_fifo_reader;

  localparam logic [63:0] PAD = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } rec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [511:0] fifo_dout = '0;
  logic         fifo_empty = 1'b1;
  logic         fifo_rd_en;
  logic [63:0]  rec_data;
  logic         rec_valid;
  logic         rec_ready = 1'b0;
  logic         rec_last;
  logic [31:0]  line_cnt;
  logic [31:0]  pad_cnt;
  logic         busy;

  logic [511:0] np_dout = '0;
  logic         np_empty = 1'b1;
  logic         np_rd_en;
  logic [63:0]  np_data;
  logic         np_valid;
  logic         np_last;
  logic [31:0]  np_line_cnt;
  logic [31:0]  np_pad_cnt;
  logic         np_busy;

  capture_fifo_reader u_dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_dout_i  (fifo_dout),
    .fifo_empty_i (fifo_empty),
    .fifo_rd_en_o (fifo_rd_en),
    .rec_data_o   (rec_data),
    .rec_valid_o  (rec_valid),
    .rec_ready_i  (rec_ready),
    .rec_last_o   (rec_last),
    .line_cnt_o   (line_cnt),
    .pad_cnt_o    (pad_cnt),
    .busy_o       (busy)
  );

  capture_fifo_reader #(.SKIP_PAD(1'b0)) u_nopad (
    .clk          (clk),
    .rst          (rst),
    .fifo_dout_i  (np_dout),
    .fifo_empty_i (np_empty),
    .fifo_rd_en_o (np_rd_en),
    .rec_data_o   (np_data),
    .rec_valid_o  (np_valid),
    .rec_ready_i  (1'b1),
    .rec_last_o   (np_last),
    .line_cnt_o   (np_line_cnt),
    .pad_cnt_o    (np_pad_cnt),
    .busy_o       (np_busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [511:0] fifo_q[$];
  rec_t         sb[$];
  int unsigned  pops[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard compare, hold stability, first-record latency, pad cycle.
  logic        held = 1'b0;
  logic [63:0] held_data = '0;
  logic        held_last = 1'b0;
  logic        pad_next = 1'b0;
  logic        lat_armed = 1'b0;
  int unsigned pop_cyc = 0;

  always @(negedge clk) begin
    rec_t exp_r;
    if (rst) begin
      held      = 1'b0;
      pad_next  = 1'b0;
      lat_armed = 1'b0;
    end else begin
      if (pad_next) begin
        check("pad_cycle_valid", {63'd0, rec_valid}, 64'd0);
        pad_next = 1'b0;
      end
      if (held) begin
        check("hold_valid", {63'd0, rec_valid}, 64'd1);
        check("hold_data", rec_data, held_data);
        check("hold_last", {63'd0, rec_last}, {63'd0, held_last});
      end
      if (fifo_rd_en) begin
        pops.push_back(cyc);
        pop_cyc   = cyc;
        lat_armed = 1'b1;
      end
      if (rec_valid && lat_armed) begin
        check("first_valid_latency", 64'(cyc - pop_cyc), 64'd2);
        lat_armed = 1'b0;
      end
      if (rec_valid && rec_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_record: got %h expected no record", rec_data);
        end else begin
          exp_r = sb.pop_front();
          check("rec_data", rec_data, exp_r.data);
          check("rec_last", {63'd0, rec_last}, {63'd0, exp_r.last});
          if (exp_r.last) pad_next = 1'b1;
        end
      end
      held      = rec_valid && !rec_ready;
      held_data = rec_data;
      held_last = rec_last;
    end
  end

  // Stimulus side: one clock of FIFO model and ready pattern.
  logic        toggle_ready = 1'b0;
  logic        shown_valid = 1'b0;
  logic [63:0] shown_data = '0;

  task automatic step();
    logic pop;
    @(negedge clk);
    pop         = fifo_rd_en;
    shown_valid = rec_valid;
    shown_data  = rec_data;
    @(posedge clk);
    #1;
    if (pop && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    if (toggle_ready) rec_ready = ~rec_ready;
  endtask

  function automatic logic [511:0] mkline(input logic [63:0] base, input int nreal);
    logic [511:0] l;
    for (int i = 0; i < 8; i++) l[i*64 +: 64] = (i >= 8 - nreal) ? base + 64'(i) : PAD;
    return l;
  endfunction

  task automatic push_line(input logic [511:0] l, input int nreal);
    rec_t r;
    fifo_q.push_back(l);
    fifo_empty = 1'b0;
    for (int i = 7; i >= 8 - nreal; i--) begin
      r.data = l[i*64 +: 64];
      r.last = (nreal < 8) && (i == 8 - nreal);
      sb.push_back(r);
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || fifo_q.size() != 0 || busy) && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s: timeout with %0d records outstanding", name, sb.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, {63'd0, fifo_rd_en}, 64'd0);
    check({tag, "_valid"}, {63'd0, rec_valid}, 64'd0);
    check({tag, "_last"}, {63'd0, rec_last}, 64'd0);
    check({tag, "_data"}, rec_data, 64'd0);
    check({tag, "_line_cnt"}, {32'd0, line_cnt}, 64'd0);
    check({tag, "_pad_cnt"}, {32'd0, pad_cnt}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] np_line;
    int n;

    // Reset with a line already waiting: no pop may be issued while rst is high.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    push_line({64'h70, 64'h60, 64'h50, 64'h40, 64'h30, 64'h20, 64'h10, 64'h00}, 8);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst       = 1'b0;
    rec_ready = 1'b1;

    // Single full line.
    wait_done("full_line");
    check("full_line_cnt", {32'd0, line_cnt}, 64'd1);
    check("full_pad_cnt", {32'd0, pad_cnt}, 64'd0);

    // Padded line: A, B, C then five pad lanes.
    push_line({64'hA, 64'hB, 64'hC, PAD, PAD, PAD, PAD, PAD}, 3);
    wait_done("padded_line");
    check("padded_pad_cnt", {32'd0, pad_cnt}, 64'd5);
    check("padded_line_cnt", {32'd0, line_cnt}, 64'd2);
    check("padded_idle", {63'd0, busy}, 64'd0);

    // Backpressure: ready toggles every cycle, full line then 6-real padded line.
    toggle_ready = 1'b1;
    push_line(mkline(64'h3000_0000_0000_0000, 8), 8);
    push_line(mkline(64'h3100_0000_0000_0000, 6), 6);
    wait_done("backpressure");
    toggle_ready = 1'b0;
    rec_ready    = 1'b1;
    check("bp_line_cnt", {32'd0, line_cnt}, 64'd4);
    check("bp_pad_cnt", {32'd0, pad_cnt}, 64'd7);

    // Back-to-back full lines: one pop per line, 10 cycles apart.
    step();
    pops.delete();
    push_line(mkline(64'h4000_0000_0000_0000, 8), 8);
    push_line(mkline(64'h4100_0000_0000_0000, 8), 8);
    push_line(mkline(64'h4200_0000_0000_0000, 8), 8);
    wait_done("back_to_back");
    check("b2b_pop_count", 64'(pops.size()), 64'd3);
    if (pops.size() == 3) begin
      check("b2b_pop_gap_0", 64'(pops[1] - pops[0]), 64'd10);
      check("b2b_pop_gap_1", 64'(pops[2] - pops[1]), 64'd10);
    end
    check("b2b_line_cnt", {32'd0, line_cnt}, 64'd7);

    // Reset while lane 4 is presented with ready low.
    fifo_q.push_back(mkline(64'hA0, 8));
    fifo_empty = 1'b0;
    for (int i = 7; i >= 5; i--) begin
      rec_t r;
      r.data = 64'hA0 + 64'(i);
      r.last = 1'b0;
      sb.push_back(r);
    end
    n = 0;
    while (!(shown_valid && shown_data == 64'hA5) && n < 50) begin
      step();
      n++;
    end
    check("mid_rst_reach_lane5", {63'd0, shown_valid}, 64'd1);
    rec_ready = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    check("mid_rst_lane4_data", rec_data, 64'hA4);
    check("mid_rst_lane4_valid", {63'd0, rec_valid}, 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    check("mid_rst_sb_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    rec_ready = 1'b1;
    push_line(mkline(64'h5000_0000_0000_0000, 8), 8);
    wait_done("after_rst");
    check("after_rst_line_cnt", {32'd0, line_cnt}, 64'd1);
    check("after_rst_pad_cnt", {32'd0, pad_cnt}, 64'd0);

    // SKIP_PAD = 0: padded line passes through untouched.
    np_line = {64'h1A, 64'h1B, 64'h1C, PAD, PAD, PAD, PAD, PAD};
    @(posedge clk);
    #1;
    np_dout  = np_line;
    np_empty = 1'b0;
    @(negedge clk);
    check("np_rd_en", {63'd0, np_rd_en}, 64'd1);
    @(posedge clk);
    #1;
    np_empty = 1'b1;
    @(negedge clk);
    check("np_load_valid", {63'd0, np_valid}, 64'd0);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      check("np_valid", {63'd0, np_valid}, 64'd1);
      check("np_data", np_data, np_line[i*64 +: 64]);
      check("np_last", {63'd0, np_last}, 64'd0);
    end
    @(negedge clk);
    check("np_idle", {63'd0, np_busy}, 64'd0);
    check("np_pad_cnt", {32'd0, np_pad_cnt}, 64'd0);
    check("np_line_cnt", {32'd0, np_line_cnt}, 64'd1);

    check("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/capture_fifo_reader.md
# capture_fifo_reader

Read-side companion of the 64-to-512-bit capture merge FIFO. Pops 512-bit lines from the FIFO and unpacks each into eight 64-bit timestamp records on a valid/ready stream. Drops the all-ones alignment padding that the write side inserts, and flags the last real record before that padding. Sits between the merge FIFO read port and the record/DMA formatter.

## Interface
Parameters:
- PAD_WORD, 64'hFFFF_FFFF_FFFF_FFFF, padding pattern written by the write-side aligner.
- SKIP_PAD, 1, 1 = drop padding and generate rec_last_o; 0 = pass every lane through as data.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset: synchronous, active-high.
- fifo_dout_i, in, 512, FIFO read data (standard mode: valid 1 cycle after fifo_rd_en_o).
- fifo_empty_i, in, 1, FIFO empty.
- fifo_rd_en_o, out, 1, FIFO pop.
- rec_data_o, out, 64, unpacked record.
- rec_valid_o, out, 1, record valid.
- rec_ready_i, in, 1, downstream ready.
- rec_last_o, out, 1, last real record of a padded line; qualified by rec_valid_o.
- line_cnt_o, out, 32, lines popped.
- pad_cnt_o, out, 32, padding lanes dropped.
- busy_o, out, 1, high in any state other than IDLE.

## Operation
- Lane order: lane 7 = fifo_dout_i[511:448] is the oldest word; lane 0 = [63:0] is the newest. Records are emitted lane 7 down to lane 0.
- Padding appears only at the tail of a line, in lanes below the last real word. Upstream guarantees that real records never equal PAD_WORD.
- FSM states: IDLE, LOAD, UNPACK.
- IDLE:
  - fifo_rd_en_o = !fifo_empty_i (combinational, forced 0 during rst).
  - If fifo_rd_en_o is high, go to LOAD.
- LOAD:
  - Capture fifo_dout_i into the line register.
  - Set lane = 7.
  - Increment line_cnt_o.
  - Go to UNPACK.
- UNPACK:
  - pad = SKIP_PAD && line[lane] == PAD_WORD.
  - rec_data_o = line[lane].
  - rec_valid_o = !pad.
  - rec_last_o = rec_valid_o && SKIP_PAD && lane != 0 && line[lane-1] == PAD_WORD.
  - If pad: pad_cnt_o += lane+1 (lane is 3 bits, count is 4 bits zero-extended), then go to IDLE.
  - Else, on rec_valid_o && rec_ready_i: if lane == 0 go to IDLE, otherwise decrement lane.
  - If rec_ready_i is low, hold rec_data_o, rec_valid_o and rec_last_o stable.
- rec_valid_o never drops without a handshake.
- Counters wrap modulo 2^32.
- SKIP_PAD = 0: all 8 lanes are emitted, rec_last_o is constant 0, and pad_cnt_o stays 0.
- No pop is issued while a line is held, so FIFO underflow is impossible.
- FIFO full/overflow is the write side's concern.
- rst mid-line:
  - The held line is discarded and the state returns to IDLE.
  - The FIFO contents are untouched; the FIFO shares rst via its own srst.

## Timing
- Reset values: fifo_rd_en_o 0, rec_valid_o 0, rec_last_o 0, rec_data_o 0, line_cnt_o 0, pad_cnt_o 0, busy_o 0, state IDLE, lane 7.
- Pop at cycle T → LOAD at T+1 (captures dout) → first record valid at T+2.
- Latency from fifo_empty_i falling (with state IDLE) to the first rec_valid_o: 2 cycles.
- Full line with rec_ready_i always high: 8 record cycles + 1 return-to-IDLE cycle. The next pop is in the IDLE cycle, so one line takes 10 cycles.
- Padded line with k real records: k record cycles, then 1 pad cycle (valid low, goes to IDLE).
- Records are never emitted during the LOAD or IDLE cycles.
- pad_cnt_o and line_cnt_o update on the clock edge that leaves UNPACK and the edge that leaves LOAD, respectively.

## Test plan
- Single full line, lanes 7..0 = 0x70..0x00, ready = 1 → rec_data 0x70, 0x60, … 0x00 on 8 consecutive cycles starting 2 cycles after the pop; rec_last never asserted; line_cnt_o = 1, pad_cnt_o = 0.
- Padded line, lanes 7..5 = A, B, C and lanes 4..0 = PAD_WORD → A, B, C emitted with rec_last only on C; valid low for the pad cycle; pad_cnt_o = 5; back to IDLE.
- Backpressure: ready toggles 1/0 every cycle during a full line → data and last held stable while ready = 0; all 8 records delivered in order with no duplicates and no loss.
- Back-to-back lines with the FIFO non-empty throughout → exactly one fifo_rd_en_o pulse per line, each 10 cycles apart; line_cnt_o = N after N lines.
- SKIP_PAD = 0 with a padded line → all 8 lanes emitted, including PAD_WORD values; rec_last_o = 0; pad_cnt_o = 0.
- rst asserted while lane = 4 with ready = 0 → the next cycle shows every output at its reset value; after release and FIFO non-empty, the next line starts at lane 7.
